// File: rtl/instruction_fetch_unit_pkg.sv
// Shared core definitions for the RV32I fetch front end:
// reset PC, the NOP filler word and the fetch-state encoding.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch unit: owns the PC, fetches one word at a time over
// req/gnt + rvalid, buffers it for decode, honours redirects.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         valid_q, valid_d;
  logic         stale_q, stale_d;
  logic         req_q, req_d;
  logic         mis_q, mis_d;

  // Next-state logic: normal fetch sequencing, then redirect override.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    stale_d   = stale_q;
    mis_d     = 1'b0;
    unique case (state_q)
      ST_RESET: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (stale_q) begin
            stale_d = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 32'd4;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_RESET;
    endcase
    if (redirect && (state_q != ST_RESET)) begin
      pc_d      = align_pc(redirect_target);
      valid_d   = 1'b0;
      inst_d    = NOP_INST;
      inst_pc_d = inst_pc_q;
      mis_d     = |redirect_target[1:0];
      unique case (state_q)
        ST_REQ: begin
          state_d = imem_gnt ? ST_WAIT : ST_REQ;
          stale_d = imem_gnt;
        end
        ST_WAIT: begin
          state_d = imem_rvalid ? ST_REQ : ST_WAIT;
          stale_d = !imem_rvalid;
        end
        default: begin
          state_d = ST_REQ;
          stale_d = 1'b0;
        end
      endcase
    end
  end

  // Request is a registered decode of the next state.
  always_comb begin
    req_d = (state_d == ST_REQ);
  end

  // State, PC and output buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
      stale_q   <= 1'b0;
      req_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      stale_q   <= stale_d;
      req_q     <= req_d;
      mis_q     <= mis_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign pc_plus4     = inst_pc_q + 32'd4;
  assign inst_valid   = valid_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit: a memory
// responder, a redirect/ready driver and a decoupled monitor.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst, inst_pc, pc_plus4;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        misalign_err;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_target(redirect_target),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int consumed = 0;

  // expected PC of the next instruction delivered to decode
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          mis_exp = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_inst, hold_pc;

  // memory model knobs
  int          gnt_pct = 100;
  int          max_dly = 1;
  bit          late_rv = 1'b0;
  bit          pend = 1'b0;
  int          dly = 0;
  logic [31:0] paddr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: random grant, 1..max_dly cycle response.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      pend        = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = late_rv;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        dly--;
        if (dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end
      end
      imem_gnt = ($urandom_range(99) < gnt_pct);
      if (imem_req && imem_gnt) begin
        pend  = 1'b1;
        paddr = imem_addr;
        dly   = $urandom_range(max_dly, 1);
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard each cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (mon_en && !rst) begin
      chk(misalign_err === mis_exp, "misalign_err", misalign_err, mis_exp);
      mis_exp = redirect && (redirect_target[1:0] != 2'b00);
      if (!inst_valid) chk(inst === NOP, "nop_when_invalid", inst, NOP);
      if (hold_prev)
        chk(inst_valid === 1'b1 && inst === hold_inst && inst_pc === hold_pc,
            "hold_stable", inst_pc, hold_pc);
      if (imem_req) chk(imem_addr[1:0] === 2'b00, "addr_align", imem_addr, 32'h0);
      if (inst_valid && inst_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_inst", inst_pc, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk(inst_pc === e, "inst_pc", inst_pc, e);
          chk(inst === mem_word(e), "inst", inst, mem_word(e));
          chk(pc_plus4 === e + 32'd4, "pc_plus4", pc_plus4, e + 32'd4);
          exp_q.push_back(e + 32'd4);
          consumed++;
        end
      end
      hold_prev = inst_valid && !inst_ready && !redirect;
      hold_inst = inst;
      hold_pc   = inst_pc;
    end
  end

  function automatic logic [31:0] pick_target();
    if ($urandom_range(7) == 0)
      return 32'hFFFF_FFF0 + 32'($urandom_range(15));
    return 32'($urandom_range(1023));
  endfunction

  task automatic check_reset_vals(input string tag);
    chk(imem_req === 1'b0, {tag, "_req"}, imem_req, 32'h0);
    chk(imem_addr === RPC, {tag, "_addr"}, imem_addr, RPC);
    chk(inst === NOP, {tag, "_inst"}, inst, NOP);
    chk(inst_pc === RPC, {tag, "_inst_pc"}, inst_pc, RPC);
    chk(pc_plus4 === RPC + 32'd4, {tag, "_pc_plus4"}, pc_plus4, RPC + 32'd4);
    chk(inst_valid === 1'b0, {tag, "_valid"}, inst_valid, 32'h0);
    chk(misalign_err === 1'b0, {tag, "_misalign"}, misalign_err, 32'h0);
  endtask

  task automatic random_phase(input int n);
    logic [31:0] t;
    gnt_pct = 70;
    max_dly = 3;
    repeat (n) begin
      @(negedge clk); #1;
      inst_ready = ($urandom_range(3) != 0);
      redirect   = ($urandom_range(11) == 0);
      if (redirect) begin
        t = pick_target();
        redirect_target = t;
        exp_q.delete();
        exp_q.push_back({t[31:2], 2'b00});
      end else begin
        redirect_target = $urandom;
      end
    end
    @(negedge clk); #1;
    redirect   = 1'b0;
    inst_ready = 1'b1;
  endtask

  initial begin
    int n;
    int c0;
    // reset values
    @(negedge clk); #3;
    check_reset_vals("reset");
    // basic fetch: zero-wait grant, 1-cycle response
    @(negedge clk); #1; inst_ready = 1'b1;
    @(negedge clk); #2; rst = 1'b0; exp_q = '{RPC};
    @(negedge clk); #1; mon_en = 1'b1; #2;
    chk(imem_req === 1'b1 && imem_addr === RPC, "t1_first_req", imem_addr, RPC);
    @(negedge clk); #3;
    chk(imem_req === 1'b0, "t1_wait_no_req", imem_req, 32'h0);
    @(negedge clk); #3;
    chk(inst_valid === 1'b1, "t1_valid", inst_valid, 32'h1);
    chk(inst === 32'h0050_0093, "t1_inst", inst, 32'h0050_0093);
    chk(inst_pc === 32'h0 && pc_plus4 === 32'h4, "t1_pc", inst_pc, 32'h0);
    @(negedge clk); #3;
    chk(imem_req === 1'b1 && imem_addr === 32'h4, "t1_next_req", imem_addr, 32'h4);
    // decode stall in HOLD
    @(negedge clk); #1; inst_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); #3; n++; end while (!inst_valid && n < 20);
    chk(inst_valid === 1'b1, "t2_valid_timeout", inst_valid, 32'h1);
    repeat (5) begin
      @(negedge clk); #3;
      chk(!imem_req && inst_valid && inst_pc === 32'h4, "t2_stall", inst_pc, 32'h4);
    end
    @(negedge clk); #1; inst_ready = 1'b1;
    @(negedge clk); #3;
    chk(imem_req === 1'b1 && imem_addr === 32'h8, "t2_resume_req", imem_addr, 32'h8);
    // randomized traffic with redirects
    random_phase(3000);
    // reset in WAIT after at least one delivered instruction
    c0 = consumed;
    n = 0;
    do begin @(negedge clk); #3; n++; end
    while (!(pend && !imem_req && consumed > c0) && n < 200);
    chk(pend && consumed > c0, "t6_reach_wait", consumed, c0);
    rst = 1'b1; mon_en = 1'b0; late_rv = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    exp_q = '{RPC}; mis_exp = 1'b0; hold_prev = 1'b0;
    @(negedge clk); #1; mon_en = 1'b1; late_rv = 1'b0; #2;
    chk(imem_req === 1'b1 && imem_addr === RPC, "t6_restart_req", imem_addr, RPC);
    chk(inst_valid === 1'b0, "t6_late_rvalid_ignored", inst_valid, 32'h0);
    c0 = consumed;
    random_phase(1500);
    chk(consumed - c0 >= 50, "progress", consumed - c0, 50);
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
